// File: rtl/r5fp_idiv_radix4_if.sv
// ---------------------------------------------------------------------------
// r5fp_idiv_radix4_if
// Handshake bundle between the FP divide front-end (master) and the
// radix-4 fractional integer divider (slave).
//   idiv_N      master->slave  W  dividend (N < 2*D expected)
//   idiv_D      master->slave  W  divisor
//   idiv_strobe master->slave  1  start request, honoured while ready=1
//   idiv_Quo    slave->master  W  quotient floor(N*2^(W-1)/D)
//   idiv_Rem    slave->master  W  remainder, < D
//   idiv_done   slave->master  1  one-cycle result-valid pulse
//   idiv_ready  slave->master  1  a strobe is accepted this cycle
// ---------------------------------------------------------------------------
interface r5fp_idiv_radix4_if #(
  parameter int W = 26
);
  logic [W-1:0] idiv_N;
  logic [W-1:0] idiv_D;
  logic         idiv_strobe;
  logic [W-1:0] idiv_Quo;
  logic [W-1:0] idiv_Rem;
  logic         idiv_done;
  logic         idiv_ready;

  modport master (
    output idiv_N, idiv_D, idiv_strobe,
    input  idiv_Quo, idiv_Rem, idiv_done, idiv_ready
  );

  modport slave (
    input  idiv_N, idiv_D, idiv_strobe,
    output idiv_Quo, idiv_Rem, idiv_done, idiv_ready
  );
endinterface

// File: rtl/r5fp_idiv_radix4.sv
// ---------------------------------------------------------------------------
// r5fp_idiv_radix4
// Iterative radix-4 restoring fractional divider. On an accepted strobe it
// computes Quo = floor(N*2^(W-1)/D) and Rem = N*2^(W-1) - Quo*D, retiring two
// quotient bits per cycle over W/2 cycles, then pulses done for one cycle.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset (aborts any running operation)
//   idiv   slave modport of r5fp_idiv_radix4_if (operands, strobe, results,
//          done, ready)
// D = 0 yields Quo = all ones and Rem = 0 with unchanged latency.
// ---------------------------------------------------------------------------
module r5fp_idiv_radix4 #(
  parameter int W = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  r5fp_idiv_radix4_if.slave     idiv
);
  localparam int CW = $clog2(W / 2 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [W+1:0]   r_rem;    // partial remainder R
  logic [W-1:0]   r_shift;  // remaining dividend bits, consumed MSB first
  logic [W-1:0]   r_quo;
  logic [W+1:0]   r_d1;     // D, 2D, 3D captured once per operation
  logic [W+1:0]   r_d2;
  logic [W+1:0]   r_d3;
  logic           r_dz;     // divisor was zero
  logic           r_done;
  logic           r_ready;

  logic [W+1:0]   w_t;
  logic [W+1:0]   w_sub;
  logic [1:0]     w_q;
  logic [W+1:0]   w_r_next;
  logic [W+1:0]   w_d1_in;
  logic [W+1:0]   w_d2_in;
  logic           w_accept;
  logic           w_unused;

  assign w_accept = r_ready && idiv.idiv_strobe;
  assign w_d1_in  = {2'b00, idiv.idiv_D};
  assign w_d2_in  = {1'b0, idiv.idiv_D, 1'b0};

  // T = 4R + next two dividend bits. R < D < 2^W, so the top two bits of R
  // are never needed when the N < 2D contract holds.
  assign w_t = {r_rem[W-1:0], r_shift[W-1:W-2]};

  // Top remainder bits only matter under contract violation, where results
  // are unspecified anyway.
  assign w_unused = ^r_rem[W+1:W];

  always_comb begin
    w_q   = 2'd0;
    w_sub = '0;
    if (w_t >= r_d3) begin
      w_q   = 2'd3;
      w_sub = r_d3;
    end else if (w_t >= r_d2) begin
      w_q   = 2'd2;
      w_sub = r_d2;
    end else if (w_t >= r_d1) begin
      w_q   = 2'd1;
      w_sub = r_d1;
    end
    w_r_next = w_t - w_sub;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_shift <= '0;
      r_quo   <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_d3    <= '0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          r_shift <= {r_shift[W-3:0], 2'b00};
          r_quo   <= {r_quo[W-3:0], w_q};
          // With D = 0 every compare passes (q = 3) and R would grow without
          // bound; pin it to zero so the final Rem is 0.
          r_rem   <= r_dz ? '0 : w_r_next;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        default: begin  // S_IDLE, S_DONE: both accept a new strobe
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= S_RUN;
            r_ready <= 1'b0;
            r_cnt   <= CW'(W / 2);
            r_rem   <= {3'b000, idiv.idiv_N[W-1:1]};
            r_shift <= {idiv.idiv_N[0], {(W-1){1'b0}}};
            r_quo   <= '0;
            r_d1    <= w_d1_in;
            r_d2    <= w_d2_in;
            r_d3    <= w_d1_in + w_d2_in;
            r_dz    <= (idiv.idiv_D == '0);
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign idiv.idiv_Quo   = r_quo;
  assign idiv.idiv_Rem   = r_rem[W-1:0];
  assign idiv.idiv_done  = r_done;
  assign idiv.idiv_ready = r_ready;
endmodule
